// File: rtl/pool_ctrl_if.sv
// Stream, control and max-tree signals of the 4x4 max-pooling controller.
// The slave modport is the controller's view; the master modport is the
// view of the environment that feeds words, hosts the max-tree and drains
// pooled pixels.
interface pool_ctrl_if #(
    parameter int DW = 8
);
    logic            start;
    logic            busy;
    logic            frame_done;
    logic [4*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] pool_a;
    logic [4*DW-1:0] pool_b;
    logic [4*DW-1:0] pool_c;
    logic [4*DW-1:0] pool_d;
    logic [DW-1:0]   pool_max;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport slave (
        input  start, in_data, in_valid, pool_max, out_ready,
        output busy, frame_done, in_ready, pool_a, pool_b, pool_c, pool_d,
               out_data, out_valid, out_last
    );

    modport master (
        output start, in_data, in_valid, pool_max, out_ready,
        input  busy, frame_done, in_ready, pool_a, pool_b, pool_c, pool_d,
               out_data, out_valid, out_last
    );
endinterface

// File: rtl/pool_ctrl.sv
// Sequencing controller for a 4x4 max-pooling datapath. Buffers rows 0..2
// of each 4-row band, presents a 4x4 window to an external combinational
// max-tree on every row-3 word, and registers the max into a valid/ready
// output stream with frame start/done control.
module pool_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic        clk,
    input  logic        reset,
    pool_ctrl_if.slave  bus
);
    localparam int WPR = IMG_W / 4;
    localparam int NB  = IMG_H / 4;
    localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, FILL, POOL, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_col;
    logic [1:0]      r_row;
    logic [BW-1:0]   r_band;
    logic [4*DW-1:0] r_rowbuf [3][WPR];
    logic [DW-1:0]   r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_busy;
    logic            r_frame_done;

    logic            w_in_ready;
    logic            w_acc;
    logic            w_col_last;
    logic            w_band_last;
    logic            w_start;
    logic            w_out_hs;

    assign w_acc       = bus.in_valid & w_in_ready;
    assign w_col_last  = (r_col == CW'(WPR - 1));
    assign w_band_last = (r_band == BW'(NB - 1));
    assign w_start     = (r_state == IDLE) & bus.start;
    assign w_out_hs    = r_out_valid & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and input-ready decode
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = FILL;
            end
            FILL: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_col_last && r_row == 2'd2) w_next = POOL;
            end
            POOL: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                if (w_acc && w_col_last) w_next = w_band_last ? DRAIN : FILL;
            end
            DRAIN: begin
                if (w_out_hs && r_out_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Column / row / band counters, advanced only on accepted words
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_band <= '0;
        end else if (w_start) begin
            r_col  <= '0;
            r_row  <= '0;
            r_band <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                if (r_state == FILL) begin
                    r_row <= r_row + 2'd1;
                end else if (!w_band_last) begin
                    r_band <= r_band + 1'b1;
                    r_row  <= '0;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Row buffers for rows 0..2 of the current band (contents not reset)
    always_ff @(posedge clk) begin
        if (w_acc && r_state == FILL) r_rowbuf[r_row][r_col] <= bus.in_data;
    end

    // Output register: load on a row-3 word, hold while stalled, drop on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_acc && r_state == POOL) begin
            r_out_data  <= bus.pool_max;
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_last && w_band_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Busy flag and one-cycle frame-done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (r_state == DRAIN && w_out_hs && r_out_last) begin
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.pool_a     = r_rowbuf[0][r_col];
    assign bus.pool_b     = r_rowbuf[1][r_col];
    assign bus.pool_c     = r_rowbuf[2][r_col];
    assign bus.pool_d     = bus.in_data;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl on an 8x8 map: stimulus pushes the pooled
// maxima computed from the whole image, a negedge monitor pops on handshakes.
module tb_pool_ctrl;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pool_ctrl_if #(.DW(DW)) bus();

    pool_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural max-tree
    function automatic logic [DW-1:0] tree_max(input logic [4*DW-1:0] a, b, c, d);
        logic [16*DW-1:0] all;
        logic [DW-1:0]    m;
        all = {a, b, c, d};
        m = '0;
        for (int i = 0; i < 16; i++)
            if (all[i*DW +: DW] > m) m = all[i*DW +: DW];
        return m;
    endfunction
    assign bus.pool_max = tree_max(bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d);

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [DW-1:0] img [H][W];
    int acc_cnt = 0;
    int out_cnt = 0;
    int rdy_mode = 0;
    bit bp_hold = 1'b0;
    bit done_due = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic start_main = 1'b0;
    logic start_spur = 1'b0;

    assign bus.start = start_main | start_spur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = directed by bp_hold
    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0)      bus.out_ready = 1'b1;
        else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
        else                    bus.out_ready = !bp_hold;
    end

    // Monitor: scoreboard pops, stall stability, frame_done timing, accept count
    always @(negedge clk) begin
        if (!reset) begin
            done_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done_due || bus.frame_done) begin
                chk("frame_done", 32'(bus.frame_done), 32'(done_due));
                if (done_due) chk("busy_at_done", 32'(bus.busy), 0);
            end
            done_due = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'(bus.out_data), 32'(prev_data));
                chk("hold_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                    if (e.last) done_due = 1'b1;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    function automatic logic [4*DW-1:0] word_of(input int r, input int wc);
        return {img[r][4*wc], img[r][4*wc+1], img[r][4*wc+2], img[r][4*wc+3]};
    endfunction

    task automatic send_word(input logic [4*DW-1:0] w);
        int t;
        bit got;
        t = 0;
        got = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!got && t < 300) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
            t++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL word_accept: got no in_ready expected acceptance within 300 cycles");
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
    endtask

    // bub: 0 continuous, 1 alternate bubbles, 2 random bubbles
    task automatic run_frame(input int bub);
        int a0, o0, t;
        exp_t x;
        for (int br = 0; br < H/4; br++)
            for (int bc = 0; bc < W/4; bc++) begin
                x.data = '0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        if (img[4*br+i][4*bc+j] > x.data) x.data = img[4*br+i][4*bc+j];
                x.last = (br == H/4 - 1) && (bc == W/4 - 1);
                exp_q.push_back(x);
            end
        a0 = acc_cnt;
        o0 = out_cnt;
        pulse_start();
        for (int r = 0; r < H; r++)
            for (int wc = 0; wc < W/4; wc++) begin
                send_word(word_of(r, wc));
                if (bub == 1 || (bub == 2 && $urandom_range(0, 1) == 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
        t = 0;
        while (!bus.frame_done && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got no frame_done expected within 300 cycles");
        end
        chk("words_accepted", 32'(acc_cnt - a0), 16);
        chk("outputs_per_frame", 32'(out_cnt - o0), 4);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic stall_ctrl();
        int t, a0;
        bp_hold = 1'b1;
        t = 0;
        while (!bus.out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("bp_first_valid", 32'(bus.out_valid), 1);
        chk("bp_first_data", 32'(bus.out_data), 27);
        repeat (6) begin
            @(negedge clk);
            chk("in_ready_pool_stall", 32'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bp_hold = 1'b0;
        @(posedge clk);
        #1;
        bp_hold = 1'b1;
        a0 = acc_cnt;
        repeat (10) @(negedge clk);
        chk("fill_during_stall", 32'((acc_cnt - a0) >= 4), 1);
        chk("stall_second_data", 32'(bus.out_data), 31);
        @(posedge clk);
        #1;
        bp_hold = 1'b0;
    endtask

    task automatic spurious_starts();
        repeat (3) begin
            repeat (3) @(posedge clk);
            #1;
            start_spur = 1'b1;
            @(posedge clk);
            #1;
            start_spur = 1'b0;
        end
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        @(negedge clk);
        reset = 1'b1;
        gap();

        // Full frame, pixel = 8*r + c
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = DW'(8*r + c);
        run_frame(0);
        gap();

        // Mid-frame reset during row 2 of band 0
        pulse_start();
        for (int k = 0; k < 5; k++) send_word(word_of(k / 2, k % 2));
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        gap();
        run_frame(0);
        gap();

        // Backpressure
        rdy_mode = 2;
        fork
            run_frame(0);
            stall_ctrl();
        join
        rdy_mode = 0;
        gap();

        // Bubbles
        run_frame(1);
        gap();

        // Spurious starts while busy, then start in the frame_done cycle
        fork
            run_frame(0);
            spurious_starts();
        join
        run_frame(0);
        gap();

        // Single max pixel at (5,2)
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = '0;
        img[5][2] = 8'hFF;
        run_frame(0);
        gap();

        // Random frames with random ready and bubbles
        rdy_mode = 1;
        repeat (6) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) img[r][c] = DW'($urandom_range(0, 255));
            run_frame(2);
            gap();
        end
        rdy_mode = 0;
        gap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
